uart_tx_cfg: RTL and testbench

Parametrised, run-time-configurable UART transmitter; successor to the fixed 8N1 transmitter in the TP2 UART path. Serialises one frame per accepted word: start bit, 5–8 data bits LSB first, optional even/odd parity, then 1, 1.5 or 2 stop bits. Bit timing comes from the shared baud-rate generator's oversampling tick. Sits between the TX FIFO / ALU-result interface and the serial pin.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_parity_gen.sv | 25 ++
 rtl/uart_tx_cfg.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and receiver:
// state encodings, parity/stop codes and data-length decode.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Code 00..11 means 5..8 bits; never exceeds the instantiated data width.
    function automatic logic [3:0] data_len(input logic [1:0] code, input int max_bits);
        logic [3:0] n;
        n = 4'd5 + {2'b00, code};
        if (int'(n) > max_bits) begin
            n = 4'(max_bits);
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the low 'len' bits of a word; shared by TX
// (generation) and RX (checking).
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8
)(
    input  logic [NB_DATA-1:0] data,
    input  logic [3:0]         len,
    input  logic [1:0]         mode,
    output logic               parity
);

    logic [NB_DATA-1:0] masked;

    genvar gi;
    generate
        for (gi = 0; gi < NB_DATA; gi++) begin : g_mask
            assign masked[gi] = data[gi] & (32'(gi) < 32'(len));
        end
    endgenerate

    assign parity = (^masked) ^ (mode == PAR_ODD);

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter: start, 5-8 data bits LSB first,
// optional parity, 1/1.5/2 stop bits, timed by an oversampling tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int NB_TICK_CNT = $clog2(2*OVERSAMPLE)
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    input  logic [NB_DATA-1:0] i_tx_data,
    input  logic [1:0]         i_data_bits,
    input  logic [1:0]         i_parity,
    input  logic [1:0]         i_stop,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done_tick
);

    localparam logic [NB_TICK_CNT-1:0] BIT_LAST     = NB_TICK_CNT'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP1P5_LAST = NB_TICK_CNT'(3*OVERSAMPLE/2 - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP2_LAST   = NB_TICK_CNT'(2*OVERSAMPLE - 1);

    tx_state_t                state_reg, state_next;
    logic [NB_TICK_CNT-1:0]   tick_reg, tick_next;
    logic [3:0]               bit_reg, bit_next;
    logic [NB_DATA-1:0]       shift_reg, shift_next;
    logic [3:0]               len_reg, len_next;
    logic [1:0]               par_mode_reg, par_mode_next;
    logic [1:0]               stop_reg, stop_next;
    logic                     par_bit_reg, par_bit_next;
    logic                     tx_reg, tx_next;
    logic                     done_reg, done_next;

    logic [3:0]               acc_len;
    logic                     acc_parity;
    logic                     bit_end;
    logic [NB_TICK_CNT-1:0]   stop_last;

    assign acc_len = data_len(i_data_bits, NB_DATA);

    // Parity is taken from the word as presented at accept time.
    uart_parity_gen #(.NB_DATA(NB_DATA)) u_parity (
        .data   (i_tx_data),
        .len    (acc_len),
        .mode   (i_parity),
        .parity (acc_parity)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= TX_IDLE;
            tick_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            len_reg      <= '0;
            par_mode_reg <= PAR_NONE;
            stop_reg     <= STOP_1;
            par_bit_reg  <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_reg     <= tick_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            len_reg      <= len_next;
            par_mode_reg <= par_mode_next;
            stop_reg     <= stop_next;
            par_bit_reg  <= par_bit_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_next     = tick_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        len_next      = len_reg;
        par_mode_next = par_mode_reg;
        stop_next     = stop_reg;
        par_bit_next  = par_bit_reg;
        done_next     = 1'b0;
        tx_next       = 1'b1;
        bit_end       = i_s_tick && (tick_reg == BIT_LAST);

        case (stop_reg)
            STOP_1:   stop_last = BIT_LAST;
            STOP_1P5: stop_last = STOP1P5_LAST;
            default:  stop_last = STOP2_LAST;
        endcase

        case (state_reg)
            TX_IDLE: begin
                if (i_tx_valid) begin
                    state_next    = TX_START;
                    tick_next     = '0;
                    bit_next      = '0;
                    shift_next    = i_tx_data;
                    len_next      = acc_len;
                    par_mode_next = i_parity;
                    stop_next     = i_stop;
                    par_bit_next  = acc_parity;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tick_next  = '0;
                    state_next = TX_DATA;
                end else if (i_s_tick) begin
                    tick_next = tick_reg + NB_TICK_CNT'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    tick_next  = '0;
                    shift_next = shift_reg >> 1;
                    bit_next   = bit_reg + 4'd1;
                    if (bit_reg == len_reg - 4'd1) begin
                        bit_next   = '0;
                        state_next = (par_mode_reg == PAR_EVEN || par_mode_reg == PAR_ODD)
                                     ? TX_PARITY : TX_STOP;
                    end
                end else if (i_s_tick) begin
                    tick_next = tick_reg + NB_TICK_CNT'(1);
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    tick_next  = '0;
                    state_next = TX_STOP;
                end else if (i_s_tick) begin
                    tick_next = tick_reg + NB_TICK_CNT'(1);
                end
            end
            TX_STOP: begin
                if (i_s_tick) begin
                    if (tick_reg == stop_last) begin
                        tick_next  = '0;
                        state_next = TX_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        tick_next = tick_reg + NB_TICK_CNT'(1);
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                tick_next  = '0;
                bit_next   = '0;
            end
        endcase

        // Line level follows the state being entered, so it stays registered.
        case (state_next)
            TX_START:  tx_next = 1'b0;
            TX_DATA:   tx_next = shift_next[0];
            TX_PARITY: tx_next = par_bit_next;
            default:   tx_next = 1'b1;
        endcase
    end

    assign o_tx           = tx_reg;
    assign o_tx_ready     = (state_reg == TX_IDLE);
    assign o_busy         = (state_reg != TX_IDLE);
    assign o_tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: the serial line is captured once per
// active tick and compared with a frame built from the line-format rules.
module tb_uart_tx_cfg;

    localparam int NB_DATA = 8;
    localparam int OS      = 16;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_s_tick;
    logic               i_tx_valid;
    logic               o_tx_ready;
    logic [NB_DATA-1:0] i_tx_data;
    logic [1:0]         i_data_bits;
    logic [1:0]         i_parity;
    logic [1:0]         i_stop;
    logic               o_tx;
    logic               o_busy;
    logic               o_tx_done_tick;

    always #5 clk = ~clk;

    uart_tx_cfg #(.NB_DATA(NB_DATA), .OVERSAMPLE(OS)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_s_tick       (i_s_tick),
        .i_tx_valid     (i_tx_valid),
        .o_tx_ready     (o_tx_ready),
        .i_tx_data      (i_tx_data),
        .i_data_bits    (i_data_bits),
        .i_parity       (i_parity),
        .i_stop         (i_stop),
        .o_tx           (o_tx),
        .o_busy         (o_busy),
        .o_tx_done_tick (o_tx_done_tick)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] db;
        logic [1:0] par;
        logic [1:0] st;
        int         ticks;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit got[$];
    bit exp_q[$];
    int accepted = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int acc_cyc  = -1;
    int done_cyc = -2;
    bit tick_rand = 1'b0;
    bit scramble  = 1'b0;

    function automatic void check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    // Reference frame: each line level repeated for its duration in ticks.
    function automatic void append_frame(input logic [7:0] d, input logic [1:0] db,
                                         input logic [1:0] par, input logic [1:0] st);
        int n;
        int ones;
        int stop_ticks;
        bit pbit;
        n = 5 + int'(db);
        if (n > NB_DATA) n = NB_DATA;
        ones = 0;
        for (int k = 0; k < OS; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < n; b++) begin
            if (d[b]) ones++;
            for (int k = 0; k < OS; k++) exp_q.push_back(d[b]);
        end
        if (par == 2'd1 || par == 2'd2) begin
            pbit = ((ones % 2) == 1) ^ (par == 2'd2);
            for (int k = 0; k < OS; k++) exp_q.push_back(pbit);
        end
        stop_ticks = (st == 2'd0) ? OS : (st == 2'd1) ? (3 * OS) / 2 : 2 * OS;
        for (int k = 0; k < stop_ticks; k++) exp_q.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        int lim;
        lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < lim; k++) begin
            if (got[k] != exp_q[k]) return k;
        end
        return -1;
    endfunction

    function automatic void compare_stream(input string name);
        check({name, " tick count"}, got.size(), exp_q.size());
        check({name, " first bad tick"}, first_diff(), -1);
        $display("frame %s: %0d ticks captured", name, got.size());
    endfunction

    // Inputs are set before the coming edge; outputs are sampled 1ns after it.
    task automatic cycle();
        i_s_tick = tick_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (scramble) begin
            i_tx_data   = 8'($urandom);
            i_data_bits = 2'($urandom);
            i_parity    = 2'($urandom);
            i_stop      = 2'($urandom);
        end
        if (i_s_tick && o_busy) got.push_back(o_tx);
        if (i_tx_valid && o_tx_ready && !i_reset) begin
            accepted++;
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (o_tx_done_tick) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                               input logic [1:0] st, input bit hold, input bit keep, input string name);
        int a0;
        int n;
        scramble = 1'b0;
        if (!keep) got.delete();
        i_tx_data   = d;
        i_data_bits = db;
        i_parity    = par;
        i_stop      = st;
        i_tx_valid  = 1'b1;
        a0 = accepted;
        n  = 0;
        while (accepted == a0 && n < 1000) begin
            cycle();
            n++;
        end
        check({name, " accepted"}, accepted - a0, 1);
        if (!hold) i_tx_valid = 1'b0;
        check({name, " start bit on line"}, o_tx, 0);
        check({name, " busy after accept"}, o_busy, 1);
    endtask

    task automatic finish_frame(input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 3000) begin
            cycle();
            n++;
        end
        check({name, " done pulses"}, done_cnt - d0, 1);
        check({name, " ready at end"}, o_tx_ready, 1);
        check({name, " busy at end"}, o_busy, 0);
        check({name, " line idle at end"}, o_tx, 1);
        scramble = 1'b0;
        cycle();
        check({name, " done width"}, o_tx_done_tick, 0);
    endtask

    vec_t tbl[7];

    initial begin
        int d0;
        string nm;
        logic [7:0] rd;
        logic [1:0] rdb, rpar, rst;

        tbl[0] = '{8'hA5, 2'b11, 2'b00, 2'b00, 160};
        tbl[1] = '{8'hC1, 2'b10, 2'b01, 2'b00, 160};
        tbl[2] = '{8'h1F, 2'b00, 2'b10, 2'b10, 144};
        tbl[3] = '{8'h1F, 2'b00, 2'b10, 2'b01, 136};
        tbl[4] = '{8'h3C, 2'b01, 2'b01, 2'b11, 160};
        tbl[5] = '{8'h96, 2'b11, 2'b10, 2'b00, 176};
        tbl[6] = '{8'h00, 2'b00, 2'b11, 2'b00, 112};

        i_reset     = 1'b1;
        i_s_tick    = 1'b0;
        i_tx_valid  = 1'b1;
        i_tx_data   = 8'hFF;
        i_data_bits = 2'b11;
        i_parity    = 2'b00;
        i_stop      = 2'b00;
        @(posedge clk);
        #1;
        // Reset held with a word offered: nothing may start.
        repeat (3) cycle();
        check("reset o_tx", o_tx, 1);
        check("reset ready", o_tx_ready, 1);
        check("reset busy", o_busy, 0);
        check("reset done", o_tx_done_tick, 0);
        check("reset no accept", accepted, 0);
        i_tx_valid = 1'b0;
        i_reset    = 1'b0;
        repeat (4) cycle();
        check("idle ticks ignored", o_tx, 1);

        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("table[%0d]", i);
            tick_rand = (i % 2) == 1;
            start_frame(tbl[i].data, tbl[i].db, tbl[i].par, tbl[i].st, 1'b0, 1'b0, nm);
            finish_frame(nm);
            exp_q.delete();
            append_frame(tbl[i].data, tbl[i].db, tbl[i].par, tbl[i].st);
            check({nm, " frame length"}, got.size(), tbl[i].ticks);
            compare_stream(nm);
        end

        // Back-to-back with valid held: second frame accepted in the done cycle.
        tick_rand = 1'b0;
        d0 = done_cnt;
        start_frame(8'h00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, "b2b#1");
        i_tx_data = 8'hFF;
        start_frame(8'hFF, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, "b2b#2");
        check("b2b accept in done cycle", acc_cyc, done_cyc);
        check("b2b done after frame 1", done_cnt - d0, 1);
        finish_frame("b2b#2");
        check("b2b total done pulses", done_cnt - d0, 2);
        exp_q.delete();
        append_frame(8'h00, 2'b11, 2'b00, 2'b00);
        append_frame(8'hFF, 2'b11, 2'b00, 2'b00);
        compare_stream("b2b pair");

        // Configuration changed while the frame is in its data bits.
        start_frame(8'h3C, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "cfgchg");
        repeat (70) cycle();
        check("cfgchg in frame", o_busy, 1);
        i_parity    = 2'b10;
        i_stop      = 2'b10;
        i_tx_data   = 8'hFF;
        i_data_bits = 2'b00;
        finish_frame("cfgchg");
        exp_q.delete();
        append_frame(8'h3C, 2'b11, 2'b00, 2'b00);
        compare_stream("cfgchg old cfg");
        start_frame(8'h3C, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, "cfgchg next");
        finish_frame("cfgchg next");
        exp_q.delete();
        append_frame(8'h3C, 2'b11, 2'b10, 2'b00);
        compare_stream("cfgchg new cfg");

        // Reset during data bit 3 abandons the frame silently.
        start_frame(8'hA0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "midreset");
        repeat (16 + 48 + 5) cycle();
        check("midreset line low before reset", o_tx, 0);
        d0 = done_cnt;
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        check("midreset o_tx", o_tx, 1);
        check("midreset ready", o_tx_ready, 1);
        check("midreset busy", o_busy, 0);
        repeat (300) cycle();
        check("midreset no done", done_cnt - d0, 0);
        start_frame(8'h55, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, "after reset");
        finish_frame("after reset");
        exp_q.delete();
        append_frame(8'h55, 2'b11, 2'b00, 2'b00);
        compare_stream("after reset");

        // Random words and formats, inputs churned while each frame runs.
        tick_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            nm   = $sformatf("rand[%0d]", i);
            rd   = 8'($urandom);
            rdb  = 2'($urandom);
            rpar = 2'($urandom);
            rst  = 2'($urandom);
            start_frame(rd, rdb, rpar, rst, 1'b0, 1'b0, nm);
            scramble = 1'b1;
            finish_frame(nm);
            exp_q.delete();
            append_frame(rd, rdb, rpar, rst);
            compare_stream(nm);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
